// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO pointer control blocks.
// Widths, thresholds and Gray-code helpers used by both clock domains.
package fifo_pkg;

  localparam int FIFO_ADDR_W       = 3;
  localparam int FIFO_PTR_W        = FIFO_ADDR_W + 1;
  localparam int FIFO_AFULL_THRESH = 6;

  // Helpers work on a wide vector; callers cast to their own width.
  localparam int GRAY_MAX_W = 16;

  typedef logic [GRAY_MAX_W-1:0] gvec_t;

  function automatic gvec_t bin2gray(input gvec_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic gvec_t gray2bin(input gvec_t g);
    gvec_t b;
    b = '0;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter.
// Each binary bit is the XOR of all Gray bits at or above it.
module fifo_gray2bin #(
  parameter int PTR_WIDTH = 4
) (
  input  logic [PTR_WIDTH-1:0] gray,
  output logic [PTR_WIDTH-1:0] bin
);

  for (genvar i = 0; i < PTR_WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[PTR_WIDTH-1:i];
  end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side control of an async FIFO: pointers, full/level flags, overflow.
// All flags come from next-state values so they are valid the cycle they register.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = FIFO_ADDR_W,
  parameter int PTR_WIDTH    = ADDR_WIDTH + 1,
  parameter int AFULL_THRESH = FIFO_AFULL_THRESH
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  winc,
  input  logic [PTR_WIDTH-1:0]  wq2_rptr,
  input  logic                  wovf_clr,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic                  wclken,
  output logic [PTR_WIDTH-1:0]  wptr,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [PTR_WIDTH-1:0]  wlevel,
  output logic                  woverflow
);

  localparam logic [PTR_WIDTH-1:0] AF_LVL = PTR_WIDTH'(AFULL_THRESH);

  logic [PTR_WIDTH-1:0] wbin_q, wbin_d;
  logic [PTR_WIDTH-1:0] wptr_q, wptr_d;
  logic [PTR_WIDTH-1:0] wlevel_q, wlevel_d;
  logic                 wfull_q, wfull_d;
  logic                 wafull_q, wafull_d;
  logic                 wovf_q, wovf_d;

  logic [PTR_WIDTH-1:0] rbin;
  logic [PTR_WIDTH-1:0] rptr_wrap;

  fifo_gray2bin #(
    .PTR_WIDTH (PTR_WIDTH)
  ) u_rptr_g2b (
    .gray (wq2_rptr),
    .bin  (rbin)
  );

  // Full when write Gray equals read Gray with the top two bits inverted.
  assign rptr_wrap = {~wq2_rptr[PTR_WIDTH-1:PTR_WIDTH-2],
                      wq2_rptr[PTR_WIDTH-3:0]};

  assign wclken = winc & ~wfull_q;
  assign waddr  = wbin_q[ADDR_WIDTH-1:0];

  always_comb begin
    wbin_d   = wbin_q;
    wptr_d   = wptr_q;
    wlevel_d = wlevel_q;
    wfull_d  = wfull_q;
    wafull_d = wafull_q;
    wovf_d   = wovf_q;

    if (wclken) begin
      wbin_d = wbin_q + 1'b1;
    end

    wptr_d   = PTR_WIDTH'(bin2gray(gvec_t'(wbin_d)));
    wfull_d  = (wptr_d == rptr_wrap);
    wlevel_d = wbin_d - rbin;
    wafull_d = (wlevel_d >= AF_LVL);

    // A rejected write in the same cycle as a clear keeps the flag set.
    wovf_d = (winc & wfull_q) | (wovf_q & ~wovf_clr);
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wovf_q   <= wovf_d;
    end
  end

  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = wafull_q;
  assign wlevel       = wlevel_q;
  assign woverflow    = wovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for the async FIFO write-side control.
// Checks pointer sequence, flags, overflow, wrap, reset and a random run.
module tb_fifo_wr_ctrl;

  logic       wclk;
  logic       wrst_n;
  logic       winc;
  logic [3:0] wq2_rptr;
  logic       wovf_clr;
  logic [2:0] waddr;
  logic       wclken;
  logic [3:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [3:0] wlevel;
  logic       woverflow;

  int tests;
  int fails;

  logic [3:0] gtab [16];

  fifo_wr_ctrl #(
    .ADDR_WIDTH   (3),
    .PTR_WIDTH    (4),
    .AFULL_THRESH (6)
  ) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .winc         (winc),
    .wq2_rptr     (wq2_rptr),
    .wovf_clr     (wovf_clr),
    .waddr        (waddr),
    .wclken       (wclken),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .woverflow    (woverflow)
  );

  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wptr"},  32'(wptr), 0);
    chk({tag, "_wfull"}, 32'(wfull), 0);
    chk({tag, "_wlvl"},  32'(wlevel), 0);
    chk({tag, "_ovf"},   32'(woverflow), 0);
    chk({tag, "_afull"}, 32'(walmost_full), 0);
    chk({tag, "_waddr"}, 32'(waddr), 0);
  endtask

  initial begin
    int wcnt;
    int rcnt;
    int s1;
    int s2;
    int lvl;
    bit acc;
    bit mfull;
    logic [3:0] prev;

    tests = 0;
    fails = 0;
    gtab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
             4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    wrst_n   = 1'b0;
    winc     = 1'b0;
    wovf_clr = 1'b0;
    wq2_rptr = 4'h0;
    tick();
    tick();
    chk_zero("rst");

    // Fill eight slots with the read side idle
    wrst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      winc = 1'b1;
      #1;
      chk("fill_waddr", 32'(waddr), 32'(i));
      chk("fill_clken", 32'(wclken), 1);
      tick();
      chk("fill_wptr",  32'(wptr), 32'(gtab[i+1]));
      chk("fill_wlvl",  32'(wlevel), 32'(i+1));
      chk("fill_afull", 32'(walmost_full), (i+1 >= 6) ? 1 : 0);
      chk("fill_wfull", 32'(wfull), (i == 7) ? 1 : 0);
    end
    winc = 1'b0;

    // Writes while full are rejected and flagged
    winc = 1'b1;
    #1;
    chk("ovf_clken", 32'(wclken), 0);
    tick();
    chk("ovf_set", 32'(woverflow), 1);
    chk("ovf_wptr", 32'(wptr), 32'hC);
    chk("ovf_wlvl", 32'(wlevel), 8);
    tick();
    chk("ovf_set2", 32'(woverflow), 1);
    chk("ovf_wptr2", 32'(wptr), 32'hC);
    winc = 1'b0;
    tick();
    chk("ovf_hold", 32'(woverflow), 1);
    wovf_clr = 1'b1;
    tick();
    chk("ovf_clr", 32'(woverflow), 0);
    winc = 1'b1;
    tick();
    chk("ovf_setwins", 32'(woverflow), 1);
    winc     = 1'b0;
    wovf_clr = 1'b0;

    // One read frees a slot; one more write refills it
    wq2_rptr = 4'h1;
    tick();
    chk("rd_wfull", 32'(wfull), 0);
    chk("rd_wlvl", 32'(wlevel), 7);
    chk("rd_afull", 32'(walmost_full), 1);
    winc = 1'b1;
    #1;
    chk("rd_clken", 32'(wclken), 1);
    chk("rd_waddr", 32'(waddr), 0);
    tick();
    chk("rd_refull", 32'(wfull), 1);
    chk("rd_wptr", 32'(wptr), 32'hD);
    chk("rd_wlvl8", 32'(wlevel), 8);

    // Reset while full with overflow set; writes during reset ignored
    tick();
    chk("pre_rst_ovf", 32'(woverflow), 1);
    wrst_n = 1'b0;
    tick();
    chk_zero("mid_rst");
    winc     = 1'b0;
    wrst_n   = 1'b1;
    wq2_rptr = 4'h0;

    // Stream 20 writes with the read pointer trailing by two
    prev = wptr;
    for (int n = 0; n < 20; n++) begin
      winc     = 1'b1;
      wq2_rptr = gtab[((n > 0) ? n - 1 : 0) & 15];
      tick();
      chk("str_wptr", 32'(wptr), 32'(gtab[(n+1) & 15]));
      chk("str_wfull", 32'(wfull), 0);
      chk("str_wlvl", 32'(wlevel), (n == 0) ? 1 : 2);
      chk("str_ham", ($countones(wptr ^ prev) <= 1) ? 1 : 0, 1);
      prev = wptr;
    end
    winc = 1'b0;

    // Random writes against a two-stage synchronised read pointer
    wrst_n = 1'b0;
    tick();
    wrst_n = 1'b1;
    wcnt  = 0;
    rcnt  = 0;
    s1    = 0;
    s2    = 0;
    mfull = 1'b0;
    prev  = wptr;
    for (int c = 0; c < 60; c++) begin
      winc     = ($urandom_range(0, 3) != 0);
      wq2_rptr = gtab[s2 & 15];
      acc      = winc && !mfull;
      #1;
      chk("rnd_clken", 32'(wclken), 32'(acc));
      wcnt  = wcnt + int'(acc);
      lvl   = wcnt - s2;
      mfull = (lvl == 8);
      tick();
      chk("rnd_wfull", 32'(wfull), 32'(mfull));
      chk("rnd_wlvl", 32'(wlevel), 32'(lvl));
      chk("rnd_pessim", (int'(wlevel) >= wcnt - rcnt) ? 1 : 0, 1);
      chk("rnd_ham", ($countones(wptr ^ prev) <= 1) ? 1 : 0, 1);
      prev = wptr;
      s2 = s1;
      s1 = rcnt;
      if (rcnt < wcnt && $urandom_range(0, 2) == 0) begin
        rcnt++;
      end
    end
    winc = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
